dm_stage: RTL

DM_STAGE -- requirements
Module: dm_stage

---
 rtl/dm_pkg.sv | 10 +
 rtl/dm_stage_if.sv | 41 ++++
 rtl/dm_ram.sv | 18 +
 rtl/dm_stage.sv | 81 ++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared control-bit positions, FSM state type and default I/O address for dm_stage
package dm_pkg;
  localparam int PIPE_MEM_WE = 3;
  localparam int PIPE_MEM_RE = 2;
  localparam int PIPE_REG_WE = 1;
  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;
  typedef logic [0:0] dm_state_t;
  localparam dm_state_t S_IDLE = 1'b0;
  localparam dm_state_t S_WAIT = 1'b1;
endpackage

// File: rtl/dm_stage_if.sv
// dm_stage_if: EXE/DM register inputs and writeback/IO outputs of dm_stage; DM_STAGE_FWD_EN adds forwarding outputs
interface dm_stage_if;
  logic [7:0] address_output;
  logic [7:0] mux21_output;
  logic [7:0] alu_output;
  logic [3:0] pipe_stg_output;
  logic [1:0] register_read_Ra_output;
  logic [1:0] register_read_Rb_output;
  logic [7:0] wb_data;
  logic [1:0] wb_rd;
  logic       wb_we;
  logic       stall;
  logic [7:0] io_out;
`ifdef DM_STAGE_FWD_EN
  logic [7:0] fwd_data;
  logic [1:0] fwd_rd;
  logic       fwd_valid;
  logic       fwd_hit;
  modport master (
    output address_output, mux21_output, alu_output, pipe_stg_output,
           register_read_Ra_output, register_read_Rb_output,
    input  wb_data, wb_rd, wb_we, stall, io_out, fwd_data, fwd_rd, fwd_valid, fwd_hit
  );
  modport slave (
    input  address_output, mux21_output, alu_output, pipe_stg_output,
           register_read_Ra_output, register_read_Rb_output,
    output wb_data, wb_rd, wb_we, stall, io_out, fwd_data, fwd_rd, fwd_valid, fwd_hit
  );
`else
  modport master (
    output address_output, mux21_output, alu_output, pipe_stg_output,
           register_read_Ra_output, register_read_Rb_output,
    input  wb_data, wb_rd, wb_we, stall, io_out
  );
  modport slave (
    input  address_output, mux21_output, alu_output, pipe_stg_output,
           register_read_Ra_output, register_read_Rb_output,
    output wb_data, wb_rd, wb_we, stall, io_out
  );
`endif
endinterface

// File: rtl/dm_ram.sv
// dm_ram: DM_DEPTH x 8 data memory, falling-edge write, asynchronous read, no reset
module dm_ram #(
  parameter int DM_DEPTH = 256,
  parameter int AW = $clog2(DM_DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DM_DEPTH];
  // write on the same falling edge as the pipeline registers
  always_ff @(negedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dm_stage.sv
// dm_stage: data-memory pipeline stage with wait-state FSM and memory-mapped output register; DM_STAGE_FWD_EN adds forwarding outputs
module dm_stage
  import dm_pkg::*;
#(
  parameter int         DM_DEPTH    = 256,
  parameter int         WAIT_CYCLES = 0,
  parameter logic [7:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  dm_stage_if.slave  bus
);
  localparam int AW = $clog2(DM_DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
  logic       mem_we, mem_re, reg_we, is_io, go, done, commit, ram_we;
  logic [7:0] ram_rdata, rd_data;
  dm_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wb_data_q, wb_data_d, io_q, io_d;
  logic [1:0] wb_rd_q, wb_rd_d;
  logic       wb_we_q, wb_we_d;
  assign mem_we  = bus.pipe_stg_output[PIPE_MEM_WE];
  assign mem_re  = bus.pipe_stg_output[PIPE_MEM_RE] & ~mem_we;
  assign reg_we  = bus.pipe_stg_output[PIPE_REG_WE];
  assign is_io   = bus.address_output == IO_ADDR;
  assign go      = state_q == S_IDLE && (mem_we || mem_re) && WAIT_CYCLES != 0;
  assign done    = state_q == S_WAIT && cnt_q == 3'd1;
  assign commit  = (state_q == S_IDLE && !go) || done;
  assign ram_we  = rst_n & commit & mem_we & ~is_io;
  assign rd_data = is_io ? io_q : ram_rdata;
  dm_ram #(.DM_DEPTH(DM_DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (bus.address_output[AW-1:0]),
    .wdata_i (bus.mux21_output),
    .rdata_o (ram_rdata)
  );
  // next state: stores never write back, loads/ALU ops update writeback only at commit
  always_comb begin
    state_d   = go ? S_WAIT : done ? S_IDLE : state_q;
    cnt_d     = go ? WAIT_LOAD : state_q == S_WAIT ? cnt_q - 3'd1 : cnt_q;
    io_d      = (commit && mem_we && is_io) ? bus.mux21_output : io_q;
    wb_we_d   = commit && !mem_we && reg_we;
    wb_data_d = (commit && !mem_we) ? (mem_re ? rd_data : bus.alu_output) : wb_data_q;
    wb_rd_d   = (commit && !mem_we) ? bus.register_read_Ra_output : wb_rd_q;
  end
  // falling-edge state, async active-low reset aborts any pending access
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      io_q      <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      io_q      <= io_d;
      wb_we_q   <= wb_we_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
    end
  end
  assign bus.wb_data = wb_data_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_we   = wb_we_q;
  assign bus.io_out  = io_q;
  assign bus.stall   = state_q == S_WAIT;
`ifdef DM_STAGE_FWD_EN
  logic unused_bits;
  assign unused_bits   = bus.pipe_stg_output[0];
  assign bus.fwd_data  = wb_data_q;
  assign bus.fwd_rd    = wb_rd_q;
  assign bus.fwd_valid = wb_we_q;
  assign bus.fwd_hit   = wb_we_q && wb_rd_q == bus.register_read_Rb_output;
`else
  logic unused_bits;
  assign unused_bits = ^{bus.pipe_stg_output[0], bus.register_read_Rb_output};
`endif
endmodule
